// File: rtl/symmetric_fir_mac.sv
// ============================================================================
// symmetric_fir_mac : folded single-multiplier MAC for a symmetric FIR.
// Revision 1.0
// ============================================================================
`default_nettype none

module symmetric_fir_mac #(
  parameter  int DATA_W    = 24,
  parameter  int TAPS      = 102,
  parameter  int COEF_W    = 18,
  parameter  int ACC_W     = 50,
  parameter  int OUT_SHIFT = 17,
  localparam int HALF      = TAPS / 2,
  localparam int AW        = $clog2(HALF)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid_i,
  input  logic [0:TAPS-1][DATA_W-1:0]    taps_i,
  output logic [AW-1:0]                  coef_addr_o,
  input  logic signed [COEF_W-1:0]       coef_i,
  output logic [DATA_W-1:0]              y_o,
  output logic                           y_valid_o,
  output logic                           busy_o,
  output logic                           overrun_o
);

  localparam int TW = $clog2(TAPS);
  localparam int PW = DATA_W + 1 + COEF_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic signed [ACC_W:0] C_RND =
    {{(ACC_W-OUT_SHIFT+1){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W:0] C_MAX =
    {{(ACC_W+1-DATA_W){1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] C_MIN =
    {{(ACC_W+1-DATA_W){1'b1}}, 1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [AW-1:0]            r_cnt;
  logic                     r_pv;
  logic                     r_mv;
  logic signed [DATA_W:0]   r_pre;
  logic signed [PW-1:0]     r_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_y;
  logic                     r_ovr;
  logic [TW-1:0]            w_lo;
  logic [TW-1:0]            w_hi;
  logic signed [ACC_W:0]    w_rnd;
  logic signed [ACC_W:0]    w_shr;
  logic [DATA_W-1:0]        w_sat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (sample_valid_i)           w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == AW'(HALF - 1))   w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_cnt == AW'(2))          w_state_nxt = S_OUT;
      S_OUT:                                 w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o      = (r_state != S_IDLE);
    y_valid_o   = (r_state == S_OUT);
    coef_addr_o = (r_state == S_RUN) ? r_cnt : '0;
  end

  assign w_lo = TW'(r_cnt);
  assign w_hi = TW'(TAPS - 1) - w_lo;

  // Round half up, then clamp to the output range
  assign w_rnd = $signed({r_acc[ACC_W-1], r_acc}) + C_RND;
  assign w_shr = w_rnd >>> OUT_SHIFT;

  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > C_MAX)      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shr < C_MIN) w_sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  // Datapath: pre-add -> multiply -> accumulate, each stage tagged by a valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pv   <= 1'b0;
      r_mv   <= 1'b0;
      r_pre  <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_y    <= '0;
      r_ovr  <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_state_nxt != r_state) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + AW'(1);

      r_pv <= (r_state == S_RUN);
      if (r_state == S_RUN)
        r_pre <= $signed({taps_i[w_lo][DATA_W-1], taps_i[w_lo]}) +
                 $signed({taps_i[w_hi][DATA_W-1], taps_i[w_hi]});

      r_mv <= r_pv;
      if (r_pv) r_prod <= PW'(r_pre) * PW'(coef_i);

      if (r_state == S_IDLE && sample_valid_i)
        r_acc <= '0;
      else if (r_mv)
        r_acc <= r_acc + $signed({{(ACC_W-PW){r_prod[PW-1]}}, r_prod});

      // Last accumulate lands at the end of the second drain cycle
      if (r_state == S_DRAIN && r_cnt == AW'(2)) r_y <= w_sat;

      if (sample_valid_i && r_state != S_IDLE) r_ovr <= 1'b1;
    end
  end

  assign y_o       = r_y;
  assign overrun_o = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_symmetric_fir_mac.sv
// ============================================================================
// tb_symmetric_fir_mac : directed vector bench for symmetric_fir_mac.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_symmetric_fir_mac;

  localparam int DATA_W = 24;
  localparam int TAPS   = 102;
  localparam int COEF_W = 18;
  localparam int AW     = 6;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         sample_valid_i;
  logic [0:TAPS-1][DATA_W-1:0]  taps;
  logic [AW-1:0]                coef_addr_o;
  logic signed [COEF_W-1:0]     coef_i;
  logic [DATA_W-1:0]            y_o;
  logic                         y_valid_o;
  logic                         busy_o;
  logic                         overrun_o;

  int rom_mode;
  int n_vec  = 0;
  int n_fail = 0;

  logic              busy_l [0:63];
  logic              valid_l[0:63];
  logic              ovr_l  [0:63];
  logic [AW-1:0]     addr_l [0:63];
  logic [DATA_W-1:0] y_l    [0:63];

  typedef struct {
    int mode;
    int idx;   // -1 = fill every tap
    int val;
    int exp;
  } vec_t;

  vec_t vecs[9];

  symmetric_fir_mac dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid_i (sample_valid_i),
    .taps_i         (taps),
    .coef_addr_o    (coef_addr_o),
    .coef_i         (coef_i),
    .y_o            (y_o),
    .y_valid_o      (y_valid_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk = ~clk;

  // Coefficient ROM with one cycle of read latency
  always @(posedge clk) begin
    if (rom_mode == 1) coef_i <= 18'sd131071;
    else               coef_i <= COEF_W'((int'(coef_addr_o) + 1) * 4096);
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_taps(input int idx, input int val);
    for (int k = 0; k < TAPS; k++)
      taps[k] = (idx < 0 || k == idx) ? DATA_W'(val) : '0;
  endtask

  // Cycle c of the run starts at c0; strobe in c0 and optionally at s2, rst at r
  task automatic run_cycles(input int n, input int s2, input int r);
    for (int c = 0; c < n; c++) begin
      busy_l[c]  = busy_o;
      valid_l[c] = y_valid_o;
      ovr_l[c]   = overrun_o;
      addr_l[c]  = coef_addr_o;
      y_l[c]     = y_o;
      sample_valid_i = (c == 0) || (c == s2);
      rst            = (c == r);
      @(posedge clk); #1;
    end
    sample_valid_i = 1'b0;
    rst            = 1'b0;
  endtask

  function automatic int timing_errs(input int n);
    int e = 0;
    for (int c = 1; c < n; c++) begin
      if (busy_l[c]  != (c <= 55)) e++;
      if (valid_l[c] != (c == 55)) e++;
      if (int'(addr_l[c]) != ((c >= 1 && c <= 51) ? c - 1 : 0)) e++;
    end
    return e;
  endfunction

  function automatic int valid_count(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (valid_l[c]) k++;
    return k;
  endfunction

  initial begin
    vecs[0] = '{0,  3,  1000,     125};
    vecs[1] = '{0, 98,  1000,     125};
    vecs[2] = '{1, -1,  1000,     101999};
    vecs[3] = '{1, -1,  8388607,  8388607};
    vecs[4] = '{1, -1, -8388608, -8388608};
    vecs[5] = '{0, 20,  1000,     656};
    vecs[6] = '{0,  0, -1000,    -31};
    vecs[7] = '{0,  0,  16,       1};
    vecs[8] = '{0,  0, -16,       0};

    rst = 1'b1;
    sample_valid_i = 1'b0;
    rom_mode = 0;
    set_taps(-1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_y",       int'(y_o),         0);
    check("reset_valid",   int'(y_valid_o),   0);
    check("reset_busy",    int'(busy_o),      0);
    check("reset_overrun", int'(overrun_o),   0);
    check("reset_addr",    int'(coef_addr_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      rom_mode = vecs[i].mode;
      set_taps(vecs[i].idx, vecs[i].val);
      run_cycles(61, -1, -1);
      check($sformatf("v%0d_timing", i), timing_errs(61), 0);
      check($sformatf("v%0d_y", i),        $signed(y_l[55]), vecs[i].exp);
      check($sformatf("v%0d_y_hold", i),   $signed(y_l[60]), vecs[i].exp);
      check($sformatf("v%0d_no_ovr", i),   int'(ovr_l[60]), 0);
    end

    // Overrun: second strobe at c20 ignored, next strobe at c56 accepted
    rom_mode = 0;
    set_taps(3, 1000);
    run_cycles(56, 20, -1);
    check("ovr_c20",      int'(ovr_l[20]), 0);
    check("ovr_c21",      int'(ovr_l[21]), 1);
    check("ovr_pulses",   valid_count(56), 1);
    check("ovr_pulse_at", int'(valid_l[55]), 1);
    check("ovr_y",        $signed(y_l[55]), 125);
    set_taps(98, 2000);
    run_cycles(61, -1, -1);
    check("ovr_next_timing", timing_errs(61), 0);
    check("ovr_next_y",      $signed(y_l[55]), 250);
    check("ovr_sticky",      int'(ovr_l[60]), 1);

    // Reset mid-sample, then a fresh sample at c32
    set_taps(3, 1000);
    run_cycles(32, -1, 30);
    check("rst_busy_c30",  int'(busy_l[30]), 1);
    check("rst_busy_c31",  int'(busy_l[31]), 0);
    check("rst_y_c31",     int'(y_l[31]), 0);
    check("rst_ovr_c31",   int'(ovr_l[31]), 0);
    check("rst_no_pulse",  valid_count(32), 0);
    run_cycles(61, -1, -1);
    check("rst_next_timing", timing_errs(61), 0);
    check("rst_next_y",      $signed(y_l[55]), 125);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
